// File: rtl/force_release_ctrl.sv
// force_release_ctrl: arbitrates force/release/readback commands from NUM_REQ
// requesters onto NUM_SIG forceable W-bit signals. Holds per-bit force-enable and
// force-value registers; eff = (en & val) | (~en & orig).
// Optional per-signal ownership is enabled by defining FORCE_CTRL_OWNER_EN.
module force_release_ctrl #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned NUM_SIG = 4,
  parameter int unsigned W       = 64,
  localparam int unsigned AW = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1,
  localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*2-1:0]   req_op,
  input  logic [NUM_REQ*AW-1:0]  req_addr,
  input  logic [NUM_REQ*W-1:0]   req_mask,
  input  logic [NUM_REQ*W-1:0]   req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [RW-1:0]          rsp_id,
  output logic                   rsp_err,
  output logic [W-1:0]           rsp_data,
  input  logic [NUM_SIG*W-1:0]   orig_val,
  output logic [NUM_SIG*W-1:0]   eff_val,
  output logic [NUM_SIG*W-1:0]   force_en_o
);

  localparam logic [1:0] OP_FORCE   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_RESP} state_e;

  state_e                    state_q;
  logic [NUM_SIG-1:0][W-1:0] en_q, val_q;
  logic [RW-1:0]             last_q, cmd_id_q, rsp_id_q;
  logic [1:0]                cmd_op_q;
  logic [AW-1:0]             cmd_addr_q;
  logic [W-1:0]              cmd_mask_q, cmd_data_q, rsp_data_q;
  logic                      rsp_valid_q, rsp_err_q;
`ifdef FORCE_CTRL_OWNER_EN
  logic [NUM_SIG-1:0]        owned_q;
  logic [NUM_SIG-1:0][RW-1:0] owner_q;
  logic                      tgt_owned_c;
  logic [RW-1:0]             tgt_owner_c;
`endif

  logic                      hi_found_c, lo_found_c, grant_found_c;
  logic [RW-1:0]             hi_id_c, lo_id_c, grant_id_c;
  logic [1:0]                sel_op_c;
  logic [AW-1:0]             sel_addr_c;
  logic [W-1:0]              sel_mask_c, sel_data_c;
  logic [NUM_SIG-1:0]        addr_hit_c;
  logic                      err_c;
  logic [W-1:0]              tgt_en_c, tgt_val_c, tgt_orig_c;
  logic [W-1:0]              nxt_en_c, nxt_val_c, rdata_c;

  // Round-robin search: first valid above last grant, else first valid at or below it
  always_comb begin
    hi_found_c = 1'b0;
    lo_found_c = 1'b0;
    hi_id_c    = '0;
    lo_id_c    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i]) begin
        if (i > int'(last_q)) begin
          if (!hi_found_c) begin
            hi_found_c = 1'b1;
            hi_id_c    = RW'(i);
          end
        end else if (!lo_found_c) begin
          lo_found_c = 1'b1;
          lo_id_c    = RW'(i);
        end
      end
    end
    grant_found_c = hi_found_c | lo_found_c;
    grant_id_c    = hi_found_c ? hi_id_c : lo_id_c;
  end

  // Mux the granted requester's fields and raise its ready while idle
  always_comb begin
    req_ready  = '0;
    sel_op_c   = '0;
    sel_addr_c = '0;
    sel_mask_c = '0;
    sel_data_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (RW'(i) == grant_id_c) begin
        sel_op_c   = req_op[i*2 +: 2];
        sel_addr_c = req_addr[i*AW +: AW];
        sel_mask_c = req_mask[i*W +: W];
        sel_data_c = req_data[i*W +: W];
        if (rst_n && (state_q == S_IDLE) && grant_found_c) req_ready[i] = 1'b1;
      end
    end
  end

  // Decode the latched command against the target signal and compute its new state
  always_comb begin
    addr_hit_c = '0;
    tgt_en_c   = '0;
    tgt_val_c  = '0;
    tgt_orig_c = '0;
`ifdef FORCE_CTRL_OWNER_EN
    tgt_owned_c = 1'b0;
    tgt_owner_c = '0;
`endif
    for (int i = 0; i < int'(NUM_SIG); i++) begin
      if (cmd_addr_q == AW'(i)) begin
        addr_hit_c[i] = 1'b1;
        tgt_en_c      = en_q[i];
        tgt_val_c     = val_q[i];
        tgt_orig_c    = orig_val[i*W +: W];
`ifdef FORCE_CTRL_OWNER_EN
        tgt_owned_c   = owned_q[i];
        tgt_owner_c   = owner_q[i];
`endif
      end
    end
    err_c = ~|addr_hit_c;
`ifdef FORCE_CTRL_OWNER_EN
    // A non-owner may not modify an owned signal; readback is always allowed
    if (((cmd_op_q == OP_FORCE) || (cmd_op_q == OP_RELEASE)) && tgt_owned_c &&
        (tgt_owner_c != cmd_id_q)) err_c = 1'b1;
`endif
    nxt_en_c  = tgt_en_c;
    nxt_val_c = tgt_val_c;
    if (!err_c) begin
      if (cmd_op_q == OP_FORCE) begin
        nxt_en_c  = tgt_en_c | cmd_mask_q;
        nxt_val_c = (tgt_val_c & ~cmd_mask_q) | (cmd_data_q & cmd_mask_q);
      end else if (cmd_op_q == OP_RELEASE) begin
        nxt_en_c  = tgt_en_c & ~cmd_mask_q;
        nxt_val_c = tgt_val_c & ~cmd_mask_q;
      end
    end
    rdata_c = err_c ? '0 : ((nxt_en_c & nxt_val_c) | (~nxt_en_c & tgt_orig_c));
  end

  // Command FSM, force registers and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      val_q       <= '0;
      last_q      <= '0;
      cmd_id_q    <= '0;
      cmd_op_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_mask_q  <= '0;
      cmd_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef FORCE_CTRL_OWNER_EN
      owned_q     <= '0;
      owner_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found_c) begin
            cmd_id_q   <= grant_id_c;
            cmd_op_q   <= sel_op_c;
            cmd_addr_q <= sel_addr_c;
            cmd_mask_q <= sel_mask_c;
            cmd_data_q <= sel_data_c;
            last_q     <= grant_id_c;
            state_q    <= S_APPLY;
          end
        end
        S_APPLY: begin
          for (int i = 0; i < int'(NUM_SIG); i++) begin
            if (addr_hit_c[i] && !err_c) begin
              en_q[i]  <= nxt_en_c;
              val_q[i] <= nxt_val_c;
`ifdef FORCE_CTRL_OWNER_EN
              if ((cmd_op_q == OP_FORCE) && !owned_q[i]) begin
                owned_q[i] <= 1'b1;
                owner_q[i] <= cmd_id_q;
              end else if ((cmd_op_q == OP_RELEASE) && (nxt_en_c == '0)) begin
                owned_q[i] <= 1'b0;
              end
`endif
            end
          end
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_c;
          rsp_id_q    <= cmd_id_q;
          rsp_data_q  <= rdata_c;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign force_en_o = en_q;
  assign eff_val    = (en_q & val_q) | (~en_q & orig_val);

endmodule

// File: tb/tb_force_release_ctrl.sv
// Directed testbench for force_release_ctrl (NUM_REQ=2, NUM_SIG=5, W=64).
module tb_force_release_ctrl;

  localparam int NR = 2;
  localparam int NS = 5;
  localparam int W  = 64;
  localparam int AW = 3;

  localparam logic [1:0] OP_NOP = 2'b00, OP_FORCE = 2'b01, OP_RELEASE = 2'b10, OP_READ = 2'b11;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PA   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] P5   = 64'h5555_5555_5555_5555;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*2-1:0]   req_op;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*W-1:0]   req_mask, req_data;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [0:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic [NS*W-1:0]   orig_val, eff_val, force_en_o;

  int checks   = 0;
  int failures = 0;

  force_release_ctrl #(.NUM_REQ(NR), .NUM_SIG(NS), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .orig_val(orig_val), .eff_val(eff_val), .force_en_o(force_en_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sl(input logic [NS*W-1:0] v, input int s);
    return v[s*W +: W];
  endfunction

  task automatic set_req(input int r, input logic [1:0] op, input logic [2:0] addr,
                         input logic [63:0] mask, input logic [63:0] data);
    req_valid[r]       = 1'b1;
    req_op[r*2 +: 2]   = op;
    req_addr[r*AW +: AW] = addr;
    req_mask[r*W +: W] = mask;
    req_data[r*W +: W] = data;
  endtask

  // Issue one command from requester r and collect its response
  task automatic do_cmd(input int r, input logic [1:0] op, input logic [2:0] addr,
                        input logic [63:0] mask, input logic [63:0] data,
                        output logic err, output logic [63:0] d, output logic [0:0] id);
    int n;
    err = 1'bx; d = 'x; id = 'x;
    set_req(r, op, addr, mask, data);
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!req_ready[r]) begin
      failures++;
      $display("FAIL grant_timeout r=%0d req_ready=%b expected=grant", r, req_ready);
      req_valid[r] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout r=%0d rsp_valid=%b expected=1", r, rsp_valid);
      return;
    end
    err = rsp_err; d = rsp_data; id = rsp_id;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_addr = '0; req_mask = '0; req_data = '0;
    req_valid = 2'b11;
    orig_val = {NS{PA}};
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (force_en_o !== '0) begin failures++; $display("FAIL reset_force_en got=%h exp=0", force_en_o); end
    checks++; if (eff_val !== {NS{PA}}) begin failures++; $display("FAIL reset_eff got=%h exp=orig", eff_val); end
    checks++; if ({rsp_id, rsp_err, rsp_data} !== '0) begin
      failures++; $display("FAIL reset_rsp_fields id=%b err=%b data=%h exp=0", rsp_id, rsp_err, rsp_data);
    end
  endtask

  task automatic test_full_force;
    logic e; logic [63:0] d; logic [0:0] id;
    do_cmd(0, OP_FORCE, 3'd0, ONES, P5, e, d, id);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL full_force_err got=%b exp=0", e); end
    checks++; if (d !== P5) begin failures++; $display("FAIL full_force_rdata got=%h exp=%h", d, P5); end
    checks++; if (id !== 1'b0) begin failures++; $display("FAIL full_force_id got=%b exp=0", id); end
    checks++; if (sl(eff_val, 0) !== P5) begin failures++; $display("FAIL full_force_eff0 got=%h exp=%h", sl(eff_val, 0), P5); end
    checks++; if (sl(force_en_o, 0) !== ONES) begin failures++; $display("FAIL full_force_en0 got=%h exp=%h", sl(force_en_o, 0), ONES); end
    checks++; if (sl(eff_val, 1) !== PA) begin failures++; $display("FAIL full_force_eff1 got=%h exp=%h", sl(eff_val, 1), PA); end
  endtask

  task automatic test_partial;
    logic e; logic [63:0] d; logic [0:0] id;
    do_cmd(0, OP_FORCE, 3'd1, 64'h0000_0000_FFFF_FFFF, 64'h5555_5555, e, d, id);
    checks++; if (d !== 64'hAAAA_AAAA_5555_5555) begin failures++; $display("FAIL partial_rdata got=%h exp=aaaaaaaa55555555", d); end
    checks++; if (sl(eff_val, 1) !== 64'hAAAA_AAAA_5555_5555) begin failures++; $display("FAIL partial_eff1 got=%h exp=aaaaaaaa55555555", sl(eff_val, 1)); end
    checks++; if (sl(force_en_o, 1) !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL partial_en1 got=%h exp=00000000ffffffff", sl(force_en_o, 1)); end
    do_cmd(0, OP_FORCE, 3'd1, 64'h0, ONES, e, d, id);
    checks++; if (e !== 1'b0 || d !== 64'hAAAA_AAAA_5555_5555) begin failures++; $display("FAIL mask0_noop err=%b data=%h exp err=0 data=aaaaaaaa55555555", e, d); end
    checks++; if (sl(force_en_o, 1) !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL mask0_en1 got=%h exp=00000000ffffffff", sl(force_en_o, 1)); end
    do_cmd(0, OP_RELEASE, 3'd1, ONES, 64'h0, e, d, id);
    checks++; if (e !== 1'b0 || d !== PA) begin failures++; $display("FAIL release_rsp err=%b data=%h exp err=0 data=%h", e, d, PA); end
    checks++; if (sl(force_en_o, 1) !== 64'h0) begin failures++; $display("FAIL release_en1 got=%h exp=0", sl(force_en_o, 1)); end
    orig_val[1*W +: W] = 64'h1234;
    orig_val[0*W +: W] = 64'h0;
    #1;
    checks++; if (sl(eff_val, 1) !== 64'h1234) begin failures++; $display("FAIL release_follow_orig got=%h exp=1234", sl(eff_val, 1)); end
    checks++; if (sl(eff_val, 0) !== P5) begin failures++; $display("FAIL forced_ignores_orig got=%h exp=%h", sl(eff_val, 0), P5); end
    do_cmd(0, OP_RELEASE, 3'd0, 64'hFFFF_FFFF_0000_0000, 64'h0, e, d, id);
    checks++; if (d !== 64'h0000_0000_5555_5555) begin failures++; $display("FAIL partial_release_rdata got=%h exp=0000000055555555", d); end
    do_cmd(0, OP_RELEASE, 3'd0, ONES, 64'h0, e, d, id);
    checks++; if (sl(eff_val, 0) !== 64'h0 || sl(force_en_o, 0) !== 64'h0) begin
      failures++; $display("FAIL release_all_sig0 eff=%h en=%h exp=0", sl(eff_val, 0), sl(force_en_o, 0));
    end
  endtask

  task automatic test_round_robin;
    set_req(0, OP_FORCE, 3'd2, ONES, 64'hDEAD_BEEF_CAFE_F00D);
    set_req(1, OP_READ, 3'd3, 64'h0, 64'h0);
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_first_grant got=%b exp=10", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rr_busy_ready got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== PA) begin
      failures++; $display("FAIL rr_rsp1 valid=%b id=%b err=%b data=%h exp 1 1 0 %h", rsp_valid, rsp_id, rsp_err, rsp_data, PA);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
      failures++; $display("FAIL rr_second_grant rsp_valid=%b req_ready=%b exp 0 01", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'hDEAD_BEEF_CAFE_F00D) begin
      failures++; $display("FAIL rr_rsp0 valid=%b id=%b data=%h exp 1 0 deadbeefcafef00d", rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic e; logic [63:0] d; logic [0:0] id;
    logic [NS*W-1:0] exp_en;
    exp_en = '0;
    exp_en[2*W +: W] = ONES;
    do_cmd(1, OP_FORCE, 3'd5, ONES, ONES, e, d, id);
    checks++; if (e !== 1'b1 || d !== 64'h0 || id !== 1'b1) begin failures++; $display("FAIL oor_force err=%b data=%h id=%b exp 1 0 1", e, d, id); end
    checks++; if (force_en_o !== exp_en) begin failures++; $display("FAIL oor_force_en got=%h exp=%h", force_en_o, exp_en); end
    do_cmd(0, OP_READ, 3'd7, 64'h0, 64'h0, e, d, id);
    checks++; if (e !== 1'b1 || d !== 64'h0) begin failures++; $display("FAIL oor_read err=%b data=%h exp 1 0", e, d); end
    do_cmd(0, OP_RELEASE, 3'd6, ONES, 64'h0, e, d, id);
    checks++; if (e !== 1'b1 || force_en_o !== exp_en) begin failures++; $display("FAIL oor_release err=%b en=%h exp 1 %h", e, force_en_o, exp_en); end
  endtask

  task automatic test_backpressure;
    set_req(0, OP_FORCE, 3'd3, 64'hFF, 64'h0F);
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    set_req(1, OP_NOP, 3'd0, 64'h0, 64'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_id !== 1'b0 ||
          rsp_data !== 64'hAAAA_AAAA_AAAA_AA0F || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b err=%b id=%b data=%h ready=%b exp 1 0 0 aaaaaaaaaaaaaa0f 00",
                 c, rsp_valid, rsp_err, rsp_id, rsp_data, req_ready);
      end
      @(posedge clk);
    end
    #1;
    req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid;
    set_req(0, OP_FORCE, 3'd4, ONES, 64'h0);
    #1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (eff_val !== orig_val) begin failures++; $display("FAIL rst_mid_eff got=%h exp=%h", eff_val, orig_val); end
    checks++; if (force_en_o !== '0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_state en=%h valid=%b exp 0 0", force_en_o, rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || sl(eff_val, 4) !== PA) begin
      failures++; $display("FAIL rst_mid_dropped valid=%b eff4=%h exp 0 %h", rsp_valid, sl(eff_val, 4), PA);
    end
  endtask

  task automatic test_owner;
    logic e; logic [63:0] d; logic [0:0] id;
    do_cmd(0, OP_FORCE, 3'd2, ONES, 64'h1111, e, d, id);
    checks++; if (e !== 1'b0 || d !== 64'h1111) begin failures++; $display("FAIL own_force0 err=%b data=%h exp 0 1111", e, d); end
    do_cmd(1, OP_RELEASE, 3'd2, ONES, 64'h0, e, d, id);
`ifdef FORCE_CTRL_OWNER_EN
    checks++; if (e !== 1'b1 || d !== 64'h0 || sl(eff_val, 2) !== 64'h1111) begin
      failures++; $display("FAIL own_nonowner_release err=%b data=%h eff2=%h exp 1 0 1111", e, d, sl(eff_val, 2));
    end
    do_cmd(0, OP_RELEASE, 3'd2, ONES, 64'h0, e, d, id);
    checks++; if (e !== 1'b0 || sl(force_en_o, 2) !== 64'h0) begin failures++; $display("FAIL own_owner_release err=%b en2=%h exp 0 0", e, sl(force_en_o, 2)); end
    do_cmd(1, OP_FORCE, 3'd2, 64'hF0, 64'h30, e, d, id);
    checks++; if (e !== 1'b0 || d !== 64'hAAAA_AAAA_AAAA_AA3A) begin failures++; $display("FAIL own_r1_force err=%b data=%h exp 0 aaaaaaaaaaaaaa3a", e, d); end
    do_cmd(0, OP_READ, 3'd2, 64'h0, 64'h0, e, d, id);
    checks++; if (e !== 1'b0 || d !== 64'hAAAA_AAAA_AAAA_AA3A) begin failures++; $display("FAIL own_read err=%b data=%h exp 0 aaaaaaaaaaaaaa3a", e, d); end
    do_cmd(0, OP_FORCE, 3'd2, ONES, 64'h0, e, d, id);
    checks++; if (e !== 1'b1 || sl(force_en_o, 2) !== 64'hF0) begin failures++; $display("FAIL own_r0_blocked err=%b en2=%h exp 1 f0", e, sl(force_en_o, 2)); end
`else
    checks++; if (e !== 1'b0 || d !== PA || sl(force_en_o, 2) !== 64'h0) begin
      failures++; $display("FAIL any_release err=%b data=%h en2=%h exp 0 %h 0", e, d, sl(force_en_o, 2), PA);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_force();
    test_partial();
    test_round_robin();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_owner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
